// File: rtl/osd_pkg.sv
// Shared definitions for the OSD text-buffer write arbiter.
//   OSD_COLS_DEF / OSD_ROWS_DEF : default text-buffer geometry
//   OSD_BLANK_CHAR              : character used to clear the buffer
//   osd_arb_state_t             : arbiter FSM states
package osd_pkg;

  localparam int unsigned OSD_COLS_DEF   = 40;
  localparam int unsigned OSD_ROWS_DEF   = 20;
  localparam logic [7:0]  OSD_BLANK_CHAR = 8'h20;

  typedef enum logic [0:0] {
    IDLE,
    CLEAR
  } osd_arb_state_t;

endpackage

// File: rtl/osd_wr_arbiter_if.sv
// Writer-side handshake and text-buffer write port of the OSD write arbiter.
//   req_valid/req_ready : per-writer valid/ready handshake
//   req_addr/req_data   : per-writer character address and code
//   we/wr_addr/wr_data  : registered text-buffer write port
// Modports: master = writers + VRAM side (testbench), slave = arbiter.
interface osd_wr_arbiter_if #(
  parameter int unsigned NREQ = 4
);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0][15:0]  req_addr;
  logic [NREQ-1:0][7:0]   req_data;
  logic                   we;
  logic [15:0]            wr_addr;
  logic [7:0]             wr_data;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready,
    input  we,
    input  wr_addr,
    input  wr_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready,
    output we,
    output wr_addr,
    output wr_data
  );

endinterface

// File: rtl/osd_rr_arb.sv
// Generic round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request vector
//   en         : grant enable; no grant when low
//   adv        : a grant was taken this cycle; remember it as the last winner
//   gnt        : one-hot grant (combinational)
//   idx        : index of the granted requester
// The search starts just above the last winner and wraps, so after reset
// (last = NREQ-1) requester 0 has top priority.
module osd_rr_arb #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IdxW = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  input  logic            adv,
  output logic [NREQ-1:0] gnt,
  output logic [IdxW-1:0] idx
);

  logic [IdxW-1:0] last_q;
  logic            hit_hi, hit_lo;
  logic [IdxW-1:0] idx_hi, idx_lo;

  // Lowest requester above last wins; otherwise lowest at or below last.
  always_comb begin
    gnt    = '0;
    idx    = '0;
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (i > int'(last_q)) begin
          hit_hi = 1'b1;
          idx_hi = IdxW'(i);
        end else begin
          hit_lo = 1'b1;
          idx_lo = IdxW'(i);
        end
      end
    end
    if (en && (hit_hi || hit_lo)) begin
      idx      = hit_hi ? idx_hi : idx_lo;
      gnt[idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= IdxW'(NREQ - 1);
    end else if (adv) begin
      last_q <= idx;
    end
  end

endmodule

// File: rtl/osd_wr_arbiter.sv
// OSD text-buffer write arbiter: shares one VRAM write port among NREQ
// writers, round-robin, one write per cycle, with an optional clear engine
// that fills the whole buffer with CLEAR_CHAR.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : writer handshakes + registered write port (slave modport)
//   clear_req   : start-clear pulse (only with OSD_WR_ARBITER_CLEAR_EN)
//   clear_busy  : clear engine active (0 without the macro)
//   oob_err     : one-cycle pulse, an accepted write had addr >= COLS*ROWS
// Build option: define OSD_WR_ARBITER_CLEAR_EN to include the clear engine.
module osd_wr_arbiter
  import osd_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned COLS       = OSD_COLS_DEF,
  parameter int unsigned ROWS       = OSD_ROWS_DEF,
  parameter logic [7:0]  CLEAR_CHAR = OSD_BLANK_CHAR
) (
  input  logic                clk,
  input  logic                rst_n,
  osd_wr_arbiter_if.slave     bus,
`ifdef OSD_WR_ARBITER_CLEAR_EN
  input  logic                clear_req,
`endif
  output logic                clear_busy,
  output logic                oob_err
);

  localparam int unsigned DEPTH = COLS * ROWS;
  localparam int unsigned IdxW  = $clog2(NREQ);

  logic [NREQ-1:0] gnt;
  logic [IdxW-1:0] idx;
  logic            arb_en;
  logic            hs;
  logic [15:0]     sel_addr;
  logic [7:0]      sel_data;
  logic            in_range;
  logic            clr_wr;
  logic [15:0]     clr_addr;

  logic            we_q, oob_q;
  logic [15:0]     wr_addr_q;
  logic [7:0]      wr_data_q;

`ifdef OSD_WR_ARBITER_CLEAR_EN
  osd_arb_state_t  state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    arb_en   = 1'b0;
    clr_wr   = 1'b0;
    clr_addr = cnt_q;
    unique case (state_q)
      IDLE: begin
        // Clear wins over any pending writer in its request cycle.
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else begin
          arb_en = 1'b1;
        end
      end
      CLEAR: begin
        clr_wr = 1'b1;
        cnt_d  = cnt_q + 16'd1;
        if (cnt_q == 16'(DEPTH - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clear_busy = (state_q == CLEAR);
`else
  assign arb_en     = 1'b1;
  assign clr_wr     = 1'b0;
  assign clr_addr   = '0;
  assign clear_busy = 1'b0;
`endif

  // Grants are forced low while reset is asserted.
  osd_rr_arb #(
    .NREQ (NREQ)
  ) u_rr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (bus.req_valid),
    .en    (arb_en & rst_n),
    .adv   (hs),
    .gnt   (gnt),
    .idx   (idx)
  );

  assign bus.req_ready = gnt;
  // A grant is only ever given to a valid requester, so any grant is a transfer.
  assign hs       = |gnt;
  assign sel_addr = bus.req_addr[idx];
  assign sel_data = bus.req_data[idx];
  assign in_range = ({1'b0, sel_addr} < 17'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      oob_q     <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (clr_wr) begin
      we_q      <= 1'b1;
      oob_q     <= 1'b0;
      wr_addr_q <= clr_addr;
      wr_data_q <= CLEAR_CHAR;
    end else begin
      we_q  <= hs & in_range;
      oob_q <= hs & ~in_range;
      if (hs && in_range) begin
        wr_addr_q <= sel_addr;
        wr_data_q <= sel_data;
      end
    end
  end

  assign bus.we      = we_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign oob_err     = oob_q;

endmodule

// File: doc/osd_wr_arbiter.md
# osd_wr_arbiter

- Shares the single OSD text-buffer write port between `NREQ` independent writers (formatters, dispatcher, status updaters).
- Sits between those writers and the text-buffer VRAM write port (`we`/`wr_addr`/`wr_data`).
- Each writer uses a valid/ready handshake; one write is granted per cycle, round-robin.
- An optional clear engine fills the whole buffer with a blank character.

## Interface

Parameters:
- `NREQ`, 4: number of write requesters (2..8)
- `COLS`, 40: text columns
- `ROWS`, 20: text rows; `DEPTH = COLS*ROWS`, must be ≤ 65536
- `CLEAR_CHAR`, 8'h20: character written by the clear engine

Ports:
- `clk` in 1: single clock, all logic on its rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `req_valid` in `NREQ`: per-requester write request
- `req_ready` out `NREQ`: per-requester grant; combinational, one-hot or zero
- `req_addr` in `NREQ`×16: per-requester character address (row*COLS+col)
- `req_data` in `NREQ`×8: per-requester character code
- `clear_req` in 1: start-clear pulse (only with the clear macro)
- `clear_busy` out 1: clear engine active
- `we` out 1: text-buffer write enable, registered
- `wr_addr` out 16: text-buffer write address, registered
- `wr_data` out 8: text-buffer write data, registered
- `oob_err` out 1: one-cycle pulse, an accepted request had `req_addr >= DEPTH`

## Operation

States: IDLE (arbitrating) and CLEAR.

IDLE:
- Requester i is granted (`req_ready[i]=1`) when `req_valid[i]=1` and it is the first valid requester searching upward, wrapping, from `last+1`.
- `last` is the index of the most recent grant.
- A transfer completes on `req_valid[i] & req_ready[i]`; `last` is then updated to i.
- No valid requests: no grant, `last` unchanged.
- Requesters must hold addr/data stable while valid and not ready.
- In-range transfer: next cycle `we=1`, with `wr_addr`/`wr_data` equal to the granted addr/data.
- Out-of-range transfer (`addr >= DEPTH`):
  - is still accepted and consumes the grant;
  - `we` stays 0 next cycle;
  - `oob_err` pulses next cycle.
- `clear_req=1` in IDLE:
  - moves to CLEAR;
  - in that same cycle all `req_ready` are 0 (clear has priority);
  - `last` is unchanged.

CLEAR:
- A 16-bit counter `cnt` starts at 0.
- Each cycle it writes `CLEAR_CHAR` to `cnt` and increments.
- After writing `DEPTH-1`, returns to IDLE.
- `clear_busy=1` for exactly `DEPTH` cycles.
- All `req_ready=0` throughout.
- `clear_req` is ignored while in CLEAR; no restart, no queueing.

Reset (any time, including mid-clear):
- Returns to IDLE; `last=NREQ-1`, so requester 0 has top priority first.
- `cnt=0`.
- `we=0`, `wr_addr=0`, `wr_data=0`, `oob_err=0`, `clear_busy=0`, `req_ready=0`.
- A partially cleared buffer is left as-is.

## Timing

- Grant: combinational from `req_valid` and state; no combinational path from `req_addr`/`req_data` to `req_ready`.
- Write latency: 1 cycle from handshake to `we` high.
- Throughput: one write per cycle sustained.
- Fairness: with all requesters valid, each is granted once every `NREQ` cycles.
- Clear:
  - `clear_req` sampled at cycle T → `clear_busy=1` from T+1 through T+DEPTH;
  - `we=1` with addresses 0..DEPTH-1 on cycles T+2 through T+DEPTH+1;
  - first possible grant at cycle T+DEPTH+1.
- `clear_busy` is registered.

## Configuration

`OSD_WR_ARBITER_CLEAR_EN`:
- Defined: CLEAR state, counter, `clear_req` and `clear_busy` present as above.
- Undefined:
  - `clear_req` port absent;
  - `clear_busy` tied to 0;
  - the block is a pure round-robin arbiter; CLEAR state and counter not synthesized.

## Structure

- Package `osd_pkg`:
  - `OSD_COLS_DEF`/`OSD_ROWS_DEF` (40/20);
  - `OSD_BLANK_CHAR` (8'h20);
  - state enum `osd_arb_state_t` {IDLE, CLEAR}.
- Sub-module `osd_rr_arb`:
  - generic `NREQ` round-robin grant logic;
  - inputs: request vector, enable, advance;
  - outputs: one-hot grant, index.
- Top holds the FSM, clear counter, bounds check and output registers.

## Test plan

- **Single write:** reset; `req_valid[2]=1`, addr 5, data 8'h41 → `req_ready[2]=1` same cycle; next cycle `we=1`, `wr_addr=5`, `wr_data=8'h41`.
- **Round-robin:** all four valid continuously from reset → grants 0,1,2,3,0,1 on consecutive cycles; `we` high every cycle after the first.
- **Clear:** `clear_req` pulse with `req_valid[0]` held (COLS=40, ROWS=20) →
  - `req_ready` 0 for 801 cycles including the request cycle;
  - 800 writes of 8'h20 to addresses 0..799;
  - `clear_busy` high for 800 cycles;
  - requester 0 then granted.
- **Out-of-range:** addr 800 with DEPTH=800 → handshake completes; next cycle `we=0`, `oob_err=1` for one cycle.
- **Reset mid-clear:** assert `rst_n=0` at `cnt=300` → immediately `we=0`, `clear_busy=0`; after release, `req_valid[3]` alone is granted.
- **Macro off:** build without the macro; all requesters valid → pure round-robin, `clear_busy` constantly 0.
